// File: rtl/up_counter_mod_pkg.sv
// Shared constants for the loadable modulo-N up counter.
// Default width and the common terminal counts used by digit stages.
package up_counter_mod_pkg;

  localparam int COUNT_WIDTH = 4;
  localparam int BCD_MAX     = 9;
  localparam int HEX_MAX     = 15;

endpackage

// File: rtl/up_counter_mod_inc_one.sv
// Combinational increment-by-one helper.
// Wraps modulo 2^WIDTH; the caller decides when to use it.
module inc_one
  import up_counter_mod_pkg::*;
#(
  parameter int WIDTH = COUNT_WIDTH
) (
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O
);

  assign O = I + WIDTH'(1);

endmodule

// File: rtl/up_counter_mod.sv
// Loadable modulo-(MAX+1) up counter with cascade terminal count,
// registered wrap pulse and sticky overflow flag.
module up_counter_mod
  import up_counter_mod_pkg::*;
#(
  parameter int WIDTH = COUNT_WIDTH,
  parameter int MAX   = HEX_MAX
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ack,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] inc;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             at_max;
  logic             wrap_ev;

  inc_one #(.WIDTH(WIDTH)) u_inc (
    .I(q_q),
    .O(inc)
  );

  assign at_max  = (q_q == MaxV);
  // Zero-latency carry so a chained stage steps on our wrap edge.
  assign tc      = en && at_max;
  // Only the count branch wraps; clr and load take priority.
  assign wrap_ev = !clr && !load && en && at_max;

  // Next-state: clr over load over count, with clamped load.
  always_comb begin
    q_d    = q_q;
    wrap_d = wrap_ev;
    ovf_d  = ovf_q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = (d > MaxV) ? MaxV : d;
    end else if (en) begin
      q_d = at_max ? '0 : inc;
    end
    if (wrap_ev) begin
      ovf_d = 1'b1;
    end else if (ack) begin
      ovf_d = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_up_counter_mod.sv
// Directed bench for up_counter_mod: hex and BCD instances
// plus a two-digit BCD cascade.
module tb_up_counter_mod;

  logic clk;
  logic rst_n;

  logic       a_en, a_clr, a_load, a_ack;
  logic [3:0] a_d, a_q;
  logic       a_tc, a_wrap, a_ovf;

  logic       b_en, b_clr, b_load, b_ack;
  logic [3:0] b_d, b_q;
  logic       b_tc, b_wrap, b_ovf;

  logic       c_en;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, lo_wrap, lo_ovf;
  logic       hi_tc, hi_wrap, hi_ovf;

  int total = 0;
  int bad   = 0;

  up_counter_mod #(.WIDTH(4), .MAX(15)) dut_hex (
    .CLK(clk), .Reset(rst_n), .en(a_en), .clr(a_clr),
    .load(a_load), .d(a_d), .ack(a_ack), .q(a_q),
    .tc(a_tc), .wrap(a_wrap), .ovf(a_ovf)
  );

  up_counter_mod #(.WIDTH(4), .MAX(9)) dut_bcd (
    .CLK(clk), .Reset(rst_n), .en(b_en), .clr(b_clr),
    .load(b_load), .d(b_d), .ack(b_ack), .q(b_q),
    .tc(b_tc), .wrap(b_wrap), .ovf(b_ovf)
  );

  up_counter_mod #(.WIDTH(4), .MAX(9)) dut_lo (
    .CLK(clk), .Reset(rst_n), .en(c_en), .clr(1'b0),
    .load(1'b0), .d(4'd0), .ack(1'b0), .q(lo_q),
    .tc(lo_tc), .wrap(lo_wrap), .ovf(lo_ovf)
  );

  up_counter_mod #(.WIDTH(4), .MAX(9)) dut_hi (
    .CLK(clk), .Reset(rst_n), .en(lo_tc), .clr(1'b0),
    .load(1'b0), .d(4'd0), .ack(1'b0), .q(hi_q),
    .tc(hi_tc), .wrap(hi_wrap), .ovf(hi_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset;
    rst_n = 1'b0;
    a_en = 0; a_clr = 0; a_load = 0; a_ack = 0; a_d = 0;
    b_en = 0; b_clr = 0; b_load = 0; b_ack = 0; b_d = 0;
    c_en = 0;
    #20;
    total++;
    if ({a_q, a_tc, a_wrap, a_ovf, b_q, b_wrap, b_ovf,
         lo_q, hi_q} !== 15'd0) begin
      bad++;
      $display("FAIL reset got a_q=%0d b_q=%0d lo=%0d hi=%0d exp all 0",
               a_q, b_q, lo_q, hi_q);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_count_hex;
    logic [3:0] eq;
    a_en = 1'b1;
    #1;
    total++;
    if ({a_q, a_tc} !== {4'd0, 1'b0}) begin
      bad++;
      $display("FAIL hex_start got q=%0d tc=%0b exp q=0 tc=0", a_q, a_tc);
    end
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk); #1;
      eq = 4'(i % 16);
      total++;
      if ({a_q, a_tc, a_wrap, a_ovf} !==
          {eq, eq == 4'd15, i == 16, i >= 16}) begin
        bad++;
        $display("FAIL hex_cnt i=%0d got q=%0d tc=%0b w=%0b o=%0b exp q=%0d",
                 i, a_q, a_tc, a_wrap, a_ovf, eq);
      end
      if (i == 15) begin
        a_en = 1'b0;
        #1;
        total++;
        if (a_tc !== 1'b0) begin
          bad++;
          $display("FAIL hex_tc_drop got tc=%0b exp 0", a_tc);
        end
        a_en = 1'b1;
      end
    end
    a_en = 1'b0;
  endtask

  task automatic test_bcd_run;
    logic [3:0] eq;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    b_en = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk); #1;
      eq = 4'(i % 10);
      total++;
      if ({b_q, b_tc, b_wrap, b_ovf} !==
          {eq, eq == 4'd9, eq == 4'd0, i >= 10}) begin
        bad++;
        $display("FAIL bcd_run i=%0d got q=%0d tc=%0b w=%0b o=%0b exp q=%0d",
                 i, b_q, b_tc, b_wrap, b_ovf, eq);
      end
    end
    b_en = 1'b0;
  endtask

  task automatic test_load_clamp;
    b_ack = 1'b1;
    @(posedge clk); #1;
    b_ack = 1'b0;
    total++;
    if ({b_q, b_wrap, b_ovf} !== {4'd5, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL ack_clear got q=%0d w=%0b o=%0b exp q=5 w=0 o=0",
               b_q, b_wrap, b_ovf);
    end
    b_load = 1'b1; b_d = 4'd12;
    @(posedge clk); #1;
    b_load = 1'b0;
    total++;
    if ({b_q, b_tc, b_wrap, b_ovf} !== {4'd9, 3'b000}) begin
      bad++;
      $display("FAIL clamp12 got q=%0d tc=%0b w=%0b o=%0b exp q=9 0 0 0",
               b_q, b_tc, b_wrap, b_ovf);
    end
    b_en = 1'b1;
    #1;
    total++;
    if (b_tc !== 1'b1) begin
      bad++;
      $display("FAIL tc_comb got tc=%0b exp 1", b_tc);
    end
    @(posedge clk); #1;
    b_en = 1'b0;
    total++;
    if ({b_q, b_wrap, b_ovf} !== {4'd0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL clamp_wrap got q=%0d w=%0b o=%0b exp q=0 w=1 o=1",
               b_q, b_wrap, b_ovf);
    end
  endtask

  task automatic test_priority;
    b_load = 1'b1; b_d = 4'd15;
    @(posedge clk); #1;
    total++;
    if (b_q !== 4'd9) begin
      bad++;
      $display("FAIL clamp15 got q=%0d exp 9", b_q);
    end
    b_clr = 1'b1; b_en = 1'b1; b_d = 4'd4;
    #1;
    total++;
    if (b_tc !== 1'b1) begin
      bad++;
      $display("FAIL tc_all3 got tc=%0b exp 1", b_tc);
    end
    @(posedge clk); #1;
    b_clr = 1'b0; b_en = 1'b0; b_d = 4'd9;
    total++;
    if ({b_q, b_wrap, b_ovf} !== {4'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL clr_wins got q=%0d w=%0b o=%0b exp q=0 w=0 o=1",
               b_q, b_wrap, b_ovf);
    end
    @(posedge clk); #1;
    b_d = 4'd3; b_en = 1'b1;
    #1;
    total++;
    if ({b_q, b_tc} !== {4'd9, 1'b1}) begin
      bad++;
      $display("FAIL ld_en_pre got q=%0d tc=%0b exp q=9 tc=1", b_q, b_tc);
    end
    @(posedge clk); #1;
    b_load = 1'b0; b_en = 1'b0; b_ack = 1'b1;
    total++;
    if ({b_q, b_wrap, b_ovf} !== {4'd3, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL load_wins got q=%0d w=%0b o=%0b exp q=3 w=0 o=1",
               b_q, b_wrap, b_ovf);
    end
    @(posedge clk); #1;
    b_ack = 1'b0;
    total++;
    if ({b_q, b_ovf} !== {4'd3, 1'b0}) begin
      bad++;
      $display("FAIL ack_ovf got q=%0d o=%0b exp q=3 o=0", b_q, b_ovf);
    end
  endtask

  task automatic test_wrap_ack;
    b_load = 1'b1; b_d = 4'd9;
    @(posedge clk); #1;
    b_load = 1'b0; b_en = 1'b1; b_ack = 1'b1;
    @(posedge clk); #1;
    b_en = 1'b0;
    total++;
    if ({b_q, b_wrap, b_ovf} !== {4'd0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL set_wins got q=%0d w=%0b o=%0b exp q=0 w=1 o=1",
               b_q, b_wrap, b_ovf);
    end
    @(posedge clk); #1;
    b_ack = 1'b0;
    total++;
    if ({b_q, b_wrap, b_ovf} !== {4'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL ack_after got q=%0d w=%0b o=%0b exp q=0 w=0 o=0",
               b_q, b_wrap, b_ovf);
    end
  endtask

  task automatic test_async_reset;
    b_load = 1'b1; b_d = 4'd9;
    @(posedge clk); #1;
    b_load = 1'b0; b_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if ({b_q, b_wrap, b_ovf} !== {4'd7, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL pre_rst got q=%0d w=%0b o=%0b exp q=7 w=0 o=1",
               b_q, b_wrap, b_ovf);
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({b_q, b_wrap, b_ovf} !== {4'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL async_rst got q=%0d w=%0b o=%0b exp q=0 w=0 o=0",
               b_q, b_wrap, b_ovf);
    end
    #2;
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (b_q !== 4'(i)) begin
        bad++;
        $display("FAIL resume i=%0d got q=%0d exp %0d", i, b_q, i);
      end
    end
    b_en = 1'b0;
  endtask

  task automatic test_cascade;
    logic [3:0] el, eh;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    c_en = 1'b1;
    for (int i = 1; i <= 23; i++) begin
      @(posedge clk); #1;
      el = 4'(i % 10);
      eh = 4'(i / 10);
      total++;
      if ({lo_q, hi_q, lo_tc, lo_wrap, lo_ovf, hi_tc, hi_wrap, hi_ovf} !==
          {el, eh, el == 4'd9, el == 4'd0, i >= 10, 3'b000}) begin
        bad++;
        $display("FAIL cascade i=%0d got lo=%0d hi=%0d exp lo=%0d hi=%0d",
                 i, lo_q, hi_q, el, eh);
      end
    end
    c_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_hex();
    test_bcd_run();
    test_load_clamp();
    test_priority();
    test_wrap_ack();
    test_async_reset();
    test_cascade();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
